// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcodes, flag bit positions and the
// arbiter FSM state encoding.
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// 8-bit ALU: ADD/SUB with carry (borrow on SUB), bitwise AND/OR/XOR; any
// other opcode passes x through. Zero flag reflects the 8-bit result.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] x_i,
  input  logic [ALU_W-1:0] y_i,
  input  logic [2:0]       op_i,
  output logic [ALU_W-1:0] r_o,
  output logic [1:0]       flags_o
);

  logic [ALU_W:0] wide;

  always_comb begin
    wide = {1'b0, x_i};
    case (op_i)
      OP_ADD:  wide = {1'b0, x_i} + {1'b0, y_i};
      OP_SUB:  wide = {1'b0, x_i} - {1'b0, y_i};
      OP_AND:  wide = {1'b0, x_i & y_i};
      OP_OR:   wide = {1'b0, x_i | y_i};
      OP_XOR:  wide = {1'b0, x_i ^ y_i};
      default: wide = {1'b0, x_i};
    endcase
  end

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_C] = wide[ALU_W];
    flags_o[FLAG_Z] = (wide[ALU_W-1:0] == '0);
  end

  assign r_o = wide[ALU_W-1:0];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester with req & mask set,
// searching from ptr_i+1 and wrapping modulo N.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  logic [N-1:0] elig;

  assign elig = req_i & mask_i;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    // Walk from farthest to nearest so the closest eligible requester wins last.
    for (int i = N; i >= 1; i--) begin
      if (elig[(int'(ptr_i) + i) % N]) begin
        winner_o = IDX_W'((int'(ptr_i) + i) % N);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between N_REQ requesters with a registered,
// id-tagged valid/ready response. Define ALU_ARB_LOCK_EN to add lock_i.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [ALU_W*N_REQ-1:0] x_i,
  input  logic [ALU_W*N_REQ-1:0] y_i,
  input  logic [3*N_REQ-1:0]     op_i,
`ifdef ALU_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       lock_i,
`endif
  output logic [N_REQ-1:0]       gnt_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [ALU_W-1:0]       r_o,
  output logic [1:0]             flags_o,
  output logic                   busy_o
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ALU_W-1:0] x_q, x_d;
  logic [ALU_W-1:0] y_q, y_d;
  logic [2:0]       op_q, op_d;
  logic [ALU_W-1:0] r_q, r_d;
  logic [1:0]       flags_q, flags_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic [N_REQ-1:0] mask;
  logic [ID_W-1:0]  win;
  logic             win_valid;
  int               win_sel;
  logic [ALU_W-1:0] alu_r;
  logic [1:0]       alu_flags;

`ifdef ALU_ARB_LOCK_EN
  logic lock_q, lock_d;

  // While locked only the last response owner (still held in rsp_id_q) is eligible.
  always_comb begin
    mask = '0;
    for (int k = 0; k < N_REQ; k++) begin
      mask[k] = !lock_q || (rsp_id_q == ID_W'(k));
    end
  end
`else
  assign mask = '1;
`endif

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req_i    (req_i),
    .mask_i   (mask),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .valid_o  (win_valid)
  );

  assign win_sel = int'(win);

  alu u_alu (
    .x_i     (x_q),
    .y_i     (y_q),
    .op_i    (op_q),
    .r_o     (alu_r),
    .flags_o (alu_flags)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    x_d         = x_q;
    y_d         = y_q;
    op_d        = op_q;
    r_d         = r_q;
    flags_d     = flags_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
`ifdef ALU_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          x_d     = x_i[win_sel*ALU_W +: ALU_W];
          y_d     = y_i[win_sel*ALU_W +: ALU_W];
          op_d    = op_i[win_sel*3 +: 3];
          id_d    = win;
          ptr_d   = win;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        r_d         = alu_r;
        flags_d     = alu_flags;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
`ifdef ALU_ARB_LOCK_EN
          for (int k = 0; k < N_REQ; k++) begin
            if (rsp_id_q == ID_W'(k)) lock_d = lock_i[k];
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      op_q        <= '0;
      r_q         <= '0;
      flags_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      x_q         <= x_d;
      y_q         <= y_d;
      op_q        <= op_d;
      r_q         <= r_d;
      flags_q     <= flags_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef ALU_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  // Grant is a decode of the EXEC cycle, so it can never outlive that state.
  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      gnt_o[k] = (state_q == ST_EXEC) && (id_q == ID_W'(k));
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign r_o         = r_q;
  assign flags_o     = flags_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
